frame_drain_ctrl: RTL and testbench

- Read-side sequencer for the 128-bit frame FIFO.
- Watches the FIFO's frame count and issues single-cycle read requests. It waits out the FIFO's RAM read latency, then captures the frame.
- Serialises each frame as one header byte plus 16 payload bytes on a byte-wide valid/ready stream toward the USB/UART transmitter.
- Supports a Hold input that freezes draining, for post-mortem capture, while the FIFO keeps rolling.

---
 rtl/frame_drain_ctrl.sv | 128 ++++++++++++
 tb/tb_frame_drain_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_drain_ctrl.sv
// rtl/frame_drain_ctrl.sv - read-side sequencer draining 128-bit frames to a byte stream
// Each frame goes out as one status header byte followed by 16 payload bytes, LSB first.
module frame_drain_ctrl #(
   parameter int   RD_LAT   = 2,
   parameter logic HDR_MARK = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [8:0]   FramesCnt,
   input  logic [127:0] FrameOut,
   input  logic         DataOverf,
   input  logic [31:0]  LostFrames,
   output logic         FrameNext,
   input  logic         Hold,
   output logic [7:0]   TxData,
   output logic         TxValid,
   input  logic         TxReady,
   output logic [31:0]  FramesSent,
   output logic         Busy
);

   typedef enum logic [1:0] {IDLE, WAIT, HDR, DATA} state_t;

   localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

   state_t        state, state_nx;
   logic [2:0]    wait_cnt, wait_cnt_nx;
   logic [127:0]  cap, cap_nx;
   logic [7:0]    hdr, hdr_nx;
   logic [3:0]    idx, idx_nx;
   logic          ovf_sticky, ovf_nx;
   logic [31:0]   lost_snap, lost_snap_nx;
   logic [31:0]   sent_nx;
   logic          next_nx;
   logic          xfer;
   logic [4:0]    cnt_sat;

   assign TxValid = (state == HDR) || (state == DATA);
   assign Busy    = (state != IDLE);
   assign xfer    = TxValid && TxReady;
   assign cnt_sat = (FramesCnt > 9'd31) ? 5'd31 : FramesCnt[4:0];

   always_comb begin
      TxData = 8'h00;
      if (state == HDR)
         TxData = hdr;
      else if (state == DATA)
         TxData = cap[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= 3'd0;
         cap        <= '0;
         hdr        <= 8'h00;
         idx        <= 4'd0;
         ovf_sticky <= 1'b0;
         lost_snap  <= 32'd0;
         FramesSent <= 32'd0;
         FrameNext  <= 1'b0;
      end else begin
         state      <= state_nx;
         wait_cnt   <= wait_cnt_nx;
         cap        <= cap_nx;
         hdr        <= hdr_nx;
         idx        <= idx_nx;
         ovf_sticky <= ovf_nx;
         lost_snap  <= lost_snap_nx;
         FramesSent <= sent_nx;
         FrameNext  <= next_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      wait_cnt_nx  = wait_cnt;
      cap_nx       = cap;
      hdr_nx       = hdr;
      idx_nx       = idx;
      ovf_nx       = ovf_sticky | DataOverf;
      lost_snap_nx = lost_snap;
      sent_nx      = FramesSent;
      next_nx      = 1'b0;

      case (state)
         IDLE: begin
            if (FramesCnt != 9'd0 && !Hold) begin
               next_nx     = 1'b1;
               wait_cnt_nx = WAIT_INIT;
               state_nx    = WAIT;
            end
         end
         WAIT: begin
            // The request cycle itself is not counted, so capture lands RD_LAT cycles after it.
            if (!FrameNext) begin
               if (wait_cnt == 3'd0) begin
                  cap_nx       = FrameOut;
                  hdr_nx       = {HDR_MARK, ovf_sticky, (LostFrames != lost_snap), cnt_sat};
                  lost_snap_nx = LostFrames;
                  ovf_nx       = DataOverf;
                  state_nx     = HDR;
               end else begin
                  wait_cnt_nx = wait_cnt - 3'd1;
               end
            end
         end
         HDR: begin
            if (xfer) begin
               idx_nx   = 4'd0;
               state_nx = DATA;
            end
         end
         DATA: begin
            if (xfer) begin
               cap_nx = {8'h00, cap[127:8]};
               idx_nx = idx + 4'd1;
               if (idx == 4'd15) begin
                  sent_nx  = FramesSent + 32'd1;
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_frame_drain_ctrl.sv
// tb/tb_frame_drain_ctrl.sv - self-checking bench for frame_drain_ctrl
// Table-driven frames plus hand sequences for hold and mid-frame reset; bytes scored via a queue.
module tb_frame_drain_ctrl;

   localparam int RD_LAT = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [8:0]   FramesCnt;
   logic [127:0] FrameOut;
   logic         DataOverf;
   logic [31:0]  LostFrames;
   logic         FrameNext;
   logic         Hold;
   logic [7:0]   TxData;
   logic         TxValid;
   logic         TxReady;
   logic [31:0]  FramesSent;
   logic         Busy;

   frame_drain_ctrl #(.RD_LAT(RD_LAT), .HDR_MARK(1'b1)) dut (
      .clk(clk), .rst(rst), .FramesCnt(FramesCnt), .FrameOut(FrameOut),
      .DataOverf(DataOverf), .LostFrames(LostFrames), .FrameNext(FrameNext),
      .Hold(Hold), .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
      .FramesSent(FramesSent), .Busy(Busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0]  cnt;
      logic [31:0] lost;
      bit          ovf;
      bit          bp;
      logic [7:0]  hdr;
   } vec_t;

   vec_t        tbl[11];
   logic [7:0]  sb[$];
   int          npass = 0, ntotal = 0;
   int          cyc = 0, lat = 0, fn_count = 0, fn_cyc = 0, frames_done = 0, last_delta = 0;
   int          fb = 0, bp_i = 0;
   bit          bp = 0, one_shot = 1, drop_pending = 0;
   bit          hold_edge = 0, busy_prev = 0, stall_prev = 0, fn_prev = 0;
   logic [7:0]  data_prev = 8'h00, next_hdr = 8'h00, base = 8'h00;
   bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      ntotal++;
      if (ok) npass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      logic [127:0] f;
      @(posedge clk);
      #1;
      cyc++;
      hold_edge = Hold;
      if (drop_pending) begin
         FramesCnt    = 9'd0;
         drop_pending = 0;
      end
      FrameOut = {$urandom, $urandom, $urandom, $urandom};
      if (lat > 0) begin
         lat--;
         if (lat == 0) begin
            sb.push_back(next_hdr);
            for (int i = 0; i < 16; i++) begin
               f[8*i +: 8] = base + 8'(i);
               sb.push_back(base + 8'(i));
            end
            FrameOut     = f;
            base         = base + 8'd16;
            drop_pending = one_shot;
         end
      end
      if (bp) begin
         TxReady = pat[bp_i];
         bp_i    = (bp_i + 1) % 4;
      end else begin
         TxReady = 1'b1;
      end
      @(negedge clk);
      if (!rst) begin
         logic [7:0] e;
         if (stall_prev)
            check(TxValid && TxData == data_prev, "stall_hold", {TxValid, TxData}, {1'b1, data_prev});
         if (FrameNext) begin
            check(!hold_edge, "fn_during_hold", 1, 0);
            check(!fn_prev, "fn_single_pulse", 1, 0);
            fn_count++;
            fn_cyc = cyc;
            lat    = RD_LAT;
         end
         if (TxValid && TxReady) begin
            if (sb.size() == 0) begin
               check(0, "unexpected_byte", TxData, 0);
            end else begin
               e = sb.pop_front();
               check(TxData == e, (fb == 0) ? "header" : "payload", TxData, e);
            end
            fb = (fb == 16) ? 0 : fb + 1;
         end
         if (busy_prev && !Busy) begin
            frames_done++;
            last_delta = cyc - fn_cyc;
         end
         busy_prev  = Busy;
         stall_prev = TxValid && !TxReady;
         data_prev  = TxData;
         fn_prev    = FrameNext;
      end
   endtask

   task automatic wait_frame(input int prev);
      int n = 0;
      while (frames_done == prev && n < 200) begin
         tick();
         n++;
      end
      check(frames_done != prev, "frame_timeout", frames_done, prev + 1);
   endtask

   task automatic wait_fb(input int target);
      int n = 0;
      while (fb != target && n < 200) begin
         tick();
         n++;
      end
      check(fb == target, "byte_wait_timeout", fb, target);
   endtask

   initial begin
      int sent_exp = 0;
      int fn0, fd0;

      tbl[0]  = '{9'd1,   32'd0,          1'b0, 1'b0, 8'h81};
      tbl[1]  = '{9'd5,   32'd0,          1'b0, 1'b1, 8'h85};
      tbl[2]  = '{9'd300, 32'd0,          1'b0, 1'b0, 8'h9F};
      tbl[3]  = '{9'd5,   32'd3,          1'b0, 1'b0, 8'hA5};
      tbl[4]  = '{9'd5,   32'd4,          1'b1, 1'b0, 8'hE5};
      tbl[5]  = '{9'd5,   32'd4,          1'b0, 1'b0, 8'h85};
      tbl[6]  = '{9'd31,  32'd4,          1'b0, 1'b0, 8'h9F};
      tbl[7]  = '{9'd30,  32'd4,          1'b0, 1'b0, 8'h9E};
      tbl[8]  = '{9'd2,   32'hFFFF_FFFF,  1'b0, 1'b0, 8'hA2};
      tbl[9]  = '{9'd2,   32'd0,          1'b0, 1'b0, 8'hA2};
      tbl[10] = '{9'd256, 32'd0,          1'b0, 1'b0, 8'h9F};

      rst = 1'b1; FramesCnt = 9'd0; FrameOut = '0; DataOverf = 1'b0;
      LostFrames = 32'd0; Hold = 1'b0; TxReady = 1'b1;
      #2;
      check(!TxValid && !FrameNext && !Busy, "reset_ctrl", {TxValid, FrameNext, Busy}, 0);
      check(FramesSent == 0 && TxData == 0, "reset_data", {FramesSent, TxData}, 0);
      tick(); tick();
      rst = 1'b0;
      tick();

      for (int r = 0; r < 11; r++) begin
         LostFrames = tbl[r].lost;
         if (tbl[r].ovf) begin
            DataOverf = 1'b1;
            tick();
            DataOverf = 1'b0;
         end
         tick();
         next_hdr  = tbl[r].hdr;
         one_shot  = 1;
         bp        = tbl[r].bp;
         bp_i      = 0;
         fn0       = fn_count;
         fd0       = frames_done;
         FramesCnt = tbl[r].cnt;
         sent_exp++;
         wait_frame(fd0);
         bp = 0;
         for (int k = 0; k < 3; k++) tick();
         check(FramesSent == 32'(sent_exp), "frames_sent", FramesSent, sent_exp);
         check(fn_count == fn0 + 1, "one_request", fn_count - fn0, 1);
         check(sb.size() == 0, "all_bytes_sent", sb.size(), 0);
         if (!tbl[r].bp)
            check(last_delta == 20, "busy_fall_latency", last_delta, 20);
      end

      // Hold mid-frame: frame completes, nothing new until release, then immediate request.
      next_hdr  = 8'h85;
      one_shot  = 0;
      fn0       = fn_count;
      fd0       = frames_done;
      FramesCnt = 9'd5;
      wait_fb(4);
      Hold = 1'b1;
      wait_frame(fd0);
      for (int k = 0; k < 10; k++) tick();
      check(fn_count == fn0 + 1, "no_fn_while_hold", fn_count - fn0, 1);
      check(!Busy, "idle_while_hold", Busy, 0);
      Hold     = 1'b0;
      one_shot = 1;
      tick();
      check(FrameNext == 1'b1, "fn_after_release", FrameNext, 1);
      fd0 = frames_done;
      wait_frame(fd0);
      sent_exp += 2;
      check(FramesSent == 32'(sent_exp), "frames_sent_hold", FramesSent, sent_exp);
      check(sb.size() == 0, "hold_bytes_sent", sb.size(), 0);

      // Reset in the middle of the payload.
      for (int k = 0; k < 3; k++) tick();
      next_hdr  = 8'h85;
      FramesCnt = 9'd5;
      wait_fb(8);
      rst = 1'b1;
      #1;
      check(!TxValid && !Busy && TxData == 0, "async_reset_drop", {TxValid, Busy, TxData}, 0);
      check(FramesSent == 0, "async_reset_count", FramesSent, 0);
      sb.delete();
      lat = 0; drop_pending = 0; fb = 0; stall_prev = 0; busy_prev = 0; fn_prev = 0;
      FramesCnt = 9'd0;
      tick();
      rst = 1'b0;
      tick();
      next_hdr  = 8'h83;
      fd0       = frames_done;
      FramesCnt = 9'd3;
      wait_frame(fd0);
      for (int k = 0; k < 3; k++) tick();
      check(FramesSent == 1, "frames_sent_after_reset", FramesSent, 1);
      check(sb.size() == 0, "reset_bytes_sent", sb.size(), 0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
